sha_stream_arbiter: RTL
=======================

// Module: sha_stream_arbiter
// PURPOSE
//  Shares one SHA-3 absorb/squeeze pipeline between N_REQ AXI-Stream message sources.
//  - Grants the core to one source for a whole message (first beat up to and including TLAST).
//  - Muxes that source onto the core's input stream and tags it with m_tid = grantee index.
//  - Holds off all sources until the core reports the digest is complete, so one message is in flight.
//  Sits between the per-source AXI_Stream transmitters and the receiver/AXI_reg/keccak_xor chain.
// PARAMETERS
//  N_REQ       4     number of requesters (2..8)
//  DATA_WIDTH  16    TDATA width per source
//  ID_WIDTH    2     width of grant index / m_tid; must be >= clog2(N_REQ)
//  TIMEOUT     4095  max cycles in WAIT_DIG before abort; 0 disables the watchdog
// PORTS
//  ACLK         in   1                   clock, rising edge
//  ARESETn      in   1                   async active-low reset
//  s_tvalid     in   N_REQ               per-source TVALID
//  s_tdata      in   N_REQ*DATA_WIDTH    per-source TDATA; source i at [i*DW +: DW]
//  s_tlast      in   N_REQ               per-source TLAST
//  s_tuser      in   N_REQ*4             per-source TUSER (SHA mode); source i at [i*4 +: 4]
//  s_tready     out  N_REQ               per-source TREADY
//  m_tvalid     out  1                   TVALID to core
//  m_tdata      out  DATA_WIDTH          TDATA to core
//  m_tlast      out  1                   TLAST to core
//  m_tuser      out  4                   mode, latched at grant
//  m_tid        out  ID_WIDTH            grantee index
//  m_tready     in   1                   core TREADY
//  digest_done  in   1                   1-cycle pulse: core has emitted the last digest beat
//  busy         out  1                   high in any state except IDLE
//  timeout_err  out  1                   1-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset
//  - All outputs 0; state = IDLE; last_grant = N_REQ-1, so source 0 wins first; wd counter = 0.
//  - Reset asserted mid-message: outputs clear immediately, the partial message is dropped,
//    and the source must resend from its first beat.
//  States: IDLE -> GRANT -> XFER -> WAIT_DIG -> IDLE
//  - IDLE: if |s_tvalid, choose the first i with s_tvalid[i], scanning from last_grant+1 with wrap.
//    Register grant = i, m_tuser = s_tuser[i], m_tid = i; go to GRANT. All s_tready = 0.
//  - GRANT: one settling cycle. m_tvalid = 0. Go to XFER. Arbitration latency is 2 cycles from
//    s_tvalid to the first possible beat.
//  - XFER: combinational path. m_tvalid = s_tvalid[g], m_tdata = s_tdata[g], m_tlast = s_tlast[g],
//    s_tready[g] = m_tready, all other s_tready = 0.
//    A beat is s_tvalid[g] & m_tready. A beat with s_tlast[g] goes to WAIT_DIG.
//    Changes on s_tuser[g] during the message are ignored.
//  - WAIT_DIG: m_tvalid = 0, all s_tready = 0. The wd counter increments each cycle.
//    On digest_done: last_grant = g, wd = 0, go to IDLE.
//    If TIMEOUT != 0 and wd == TIMEOUT: pulse timeout_err, last_grant = g, go to IDLE.
//  - Outside WAIT_DIG, digest_done is ignored. In WAIT_DIG, digest_done takes priority over the
//    timeout when both occur in the same cycle.
//  - Grant is never revoked during XFER, regardless of how long s_tvalid[g] stays low.
//  - Non-granted sources see s_tready = 0 and must hold their data (AXI rule).
//  - m_tdata and m_tlast are don't-care when m_tvalid = 0; drive them 0.
// TESTING
//  - Single source: src0 sends 4 beats 0x1111..0x4444 with TLAST on beat 4, m_tready = 1.
//    Expect m_tid = 0, data in order, m_tlast only on beat 4, busy held until digest_done.
//  - Round-robin: src1 and src3 request together after reset. Expect src1 granted first.
//    After digest_done, expect src3; next src1 again.
//  - Backpressure: m_tready toggles 1,0,1,0 during src2's message.
//    Expect s_tready[2] to follow m_tready, no beat lost or duplicated, other s_tready = 0.
//  - Watchdog: TIMEOUT = 8, no digest_done. Expect timeout_err pulse 8 cycles into WAIT_DIG,
//    then IDLE; a pending src0 is granted next.
//  - Reset mid-XFER after 2 beats. Expect all outputs 0 asynchronously.
//    After release, src0 is re-granted and its 4-beat message passes whole.
//  - digest_done pulsed while in XFER. Expect it ignored; the state stays XFER until TLAST.

Source files
------------

// File: rtl/sha_stream_arbiter.sv
// sha_stream_arbiter: round-robin arbiter granting one AXI-Stream source at a time to a shared SHA-3 core
module sha_stream_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2,
  parameter int TIMEOUT    = 4095
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [N_REQ-1:0]            s_tvalid,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_REQ-1:0]            s_tlast,
  input  logic [N_REQ*4-1:0]          s_tuser,
  output logic [N_REQ-1:0]            s_tready,
  output logic                        m_tvalid,
  output logic [DATA_WIDTH-1:0]       m_tdata,
  output logic                        m_tlast,
  output logic [3:0]                  m_tuser,
  output logic [ID_WIDTH-1:0]         m_tid,
  input  logic                        m_tready,
  input  logic                        digest_done,
  output logic                        busy,
  output logic                        timeout_err
);
  localparam int WW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, GRANT, XFER, WAIT_DIG} state_t;
  state_t state, state_nx;
  logic [ID_WIDTH-1:0] grant, last_grant, pick;
  logic [WW-1:0] wd;
  logic [DATA_WIDTH-1:0] dat [N_REQ];
  logic [3:0] usr [N_REQ];
  logic wd_hit, beat, leave;
  for (genvar i = 0; i < N_REQ; i++) begin : g_split
    assign dat[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign usr[i] = s_tuser[i*4 +: 4];
  end
  assign wd_hit = (TIMEOUT != 0) && (wd == WW'(TIMEOUT));
  assign beat   = s_tvalid[grant] & m_tready;
  assign leave  = digest_done | wd_hit;
  assign m_tid  = grant;
  // lowest requester above last_grant wins; otherwise wrap to the lowest requester overall
  always_comb begin
    pick = last_grant;
    for (int k = N_REQ - 1; k >= 0; k--) if (s_tvalid[k]) pick = ID_WIDTH'(k);
    for (int k = N_REQ - 1; k >= 0; k--) if (s_tvalid[k] && ID_WIDTH'(k) > last_grant) pick = ID_WIDTH'(k);
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (|s_tvalid) state_nx = GRANT;
      GRANT:    state_nx = XFER;
      XFER:     if (beat && s_tlast[grant]) state_nx = WAIT_DIG;
      WAIT_DIG: if (leave) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      grant      <= '0;
      m_tuser    <= '0;
      last_grant <= ID_WIDTH'(N_REQ - 1);
      wd         <= '0;
    end else begin
      if (state == IDLE && |s_tvalid) begin
        grant   <= pick;
        m_tuser <= usr[pick];
      end
      if (state == WAIT_DIG) begin
        wd <= leave ? '0 : wd + WW'(1);
        if (leave) last_grant <= grant;
      end
    end
  always_comb begin
    m_tvalid    = (state == XFER) & s_tvalid[grant];
    m_tdata     = m_tvalid ? dat[grant] : '0;
    m_tlast     = m_tvalid & s_tlast[grant];
    s_tready    = (state == XFER) ? N_REQ'(m_tready) << grant : '0;
    busy        = state != IDLE;
    timeout_err = (state == WAIT_DIG) & wd_hit & ~digest_done;
  end
endmodule
